// File: rtl/clock_div_five.sv
// Odd-ratio clock divider with a 50% duty cycle.
// A rising-edge counter sets the phase register pos_q for the first
// (DIV-1)/2 input cycles of every output period. A falling-edge copy,
// neg_q, stretches the high time by half an input cycle. The output is
// the OR of the two, which gives a high time of DIV/2 input periods.
`timescale 1ns/1ps

module clock_div_five #(
  parameter int DIV   = 5,
  parameter int CNT_W = 5
) (
  input  logic clk_in,
  input  logic rst,
  output logic clk_div_5
);

  // Only odd ratios can be split into two equal halves on clock edges,
  // and the counter must be wide enough to hold DIV-1.
  if ((DIV < 3) || (DIV > 31) || ((DIV % 2) == 0)) begin : g_bad_div
    $error("clock_div_five: DIV must be an odd integer in 3..31, got %0d", DIV);
  end

  if (CNT_W < $clog2(DIV)) begin : g_bad_cnt_w
    $error("clock_div_five: CNT_W=%0d is too narrow for DIV=%0d", CNT_W, DIV);
  end

  // Last counter state and the number of rising-edge cycles pos_q stays high.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] CNT_HIGH = CNT_W'((DIV - 1) / 2);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             pos_nxt;
  logic             pos_q;
  logic             neg_q;

  // Next counter value and next rising-edge phase.
  // Any value at or beyond the last state wraps to zero. This covers the
  // normal wrap and also recovers from an out-of-range value.
  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path through the block can infer a latch.
    cnt_nxt = cnt + CNT_W'(1);
    if (cnt >= CNT_LAST) begin
      cnt_nxt = '0;
    end
    pos_nxt = (cnt_nxt < CNT_HIGH);
  end

  // Rising-edge counter and phase register.
  // The counter resets to its last state, so the first edge after release
  // lands on count zero and raises the output right away.
  always_ff @(posedge clk_in or negedge rst) begin
    // NOTE: reset is asynchronous, so the output drops the moment rst goes low and does not wait for a clock edge.
    if (!rst) begin
      cnt   <= CNT_LAST;
      pos_q <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments, so every flop samples its pre-edge inputs.
      cnt   <= cnt_nxt;
      pos_q <= pos_nxt;
    end
  end

  // Falling-edge copy of pos_q.
  // The output rises only while neg_q is low and falls only while pos_q is
  // already low, so the OR below cannot glitch.
  always_ff @(negedge clk_in or negedge rst) begin
    if (!rst) begin
      neg_q <= 1'b0;
    end else begin
      neg_q <= pos_q;
    end
  end

  assign clk_div_5 = pos_q | neg_q;

endmodule

// File: tb/tb_clock_div_five.sv
// Directed bench for clock_div_five. It runs three instances side by side,
// with DIV = 5, 3 and 7, from one clock and one reset.
// Expected waveform: counting half-cycles h from the first rising edge
// after reset release, the output is high while (h mod 2*DIV) < DIV.
`timescale 1ns/1ps

module tb_clock_div_five;

  logic clk_in;
  logic rst;
  logic out5;
  logic out3;
  logic out7;

  int checks = 0;
  int errors = 0;

  clock_div_five #(.DIV(5), .CNT_W(5)) u_d5 (.clk_in(clk_in), .rst(rst), .clk_div_5(out5));
  clock_div_five #(.DIV(3), .CNT_W(2)) u_d3 (.clk_in(clk_in), .rst(rst), .clk_div_5(out3));
  clock_div_five #(.DIV(7), .CNT_W(3)) u_d7 (.clk_in(clk_in), .rst(rst), .clk_div_5(out7));

  // Clock period is 30 ns, so rising edges fall at 15 + 30n and falling edges at 30n.
  initial clk_in = 1'b0;
  always #15 clk_in = ~clk_in;

  // Edge timestamps and transition counters for each output.
  time rise5_last = 0, rise5_prev = 0, fall5_last = 0, high5 = 0;
  time rise3_last = 0, rise3_prev = 0, high3 = 0;
  time rise7_last = 0, rise7_prev = 0, high7 = 0;
  int  edges5 = 0, edges3 = 0, edges7 = 0;

  always @(posedge out5) begin rise5_prev = rise5_last; rise5_last = $time; end
  always @(negedge out5) begin fall5_last = $time; high5 = $time - rise5_last; end
  always @(posedge out3) begin rise3_prev = rise3_last; rise3_last = $time; end
  always @(negedge out3) high3 = $time - rise3_last;
  always @(posedge out7) begin rise7_prev = rise7_last; rise7_last = $time; end
  always @(negedge out7) high7 = $time - rise7_last;
  always @(out5) edges5++;
  always @(out3) edges3++;
  always @(out7) edges7++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Entered 1 ns after the first rising edge following reset release.
  // Checks every half-cycle against the expected waveform.
  task automatic run_halves(input int n, input string tag);
    for (int h = 0; h < n; h++) begin
      check({tag, "_d5"}, 32'(out5), 32'((h % 10) < 5));
      check({tag, "_d3"}, 32'(out3), 32'((h % 6) < 3));
      check({tag, "_d7"}, 32'(out7), 32'((h % 14) < 7));
      check({tag, "_cnt5"}, 32'(u_d5.cnt), 32'((h / 2) % 5));
      @(clk_in);
      #1;
    end
  endtask

  initial begin
    rst = 1'b0;

    // Reset held for two input cycles: every output stays low and the counter holds DIV-1.
    for (int e = 0; e < 4; e++) begin
      @(clk_in);
      #1;
      check("rst_d5", 32'(out5), 32'd0);
      check("rst_d3", 32'(out3), 32'd0);
      check("rst_d7", 32'(out7), 32'd0);
      check("rst_cnt5", 32'(u_d5.cnt), 32'd4);
    end

    // Release reset while the clock is low. The output must stay low until the next rising edge.
    @(negedge clk_in);
    #5 rst = 1'b1;
    #1 check("rel_low_d5", 32'(out5), 32'd0);
    @(posedge clk_in);
    #1;
    edges5 = 0;
    edges3 = 0;
    edges7 = 0;
    run_halves(100, "run1");

    // Ten DIV=5 periods: period, high time, edge alignment and transition count.
    check("per5", 32'(rise5_last - rise5_prev), 32'd150);
    check("high5", 32'(high5), 32'd75);
    check("rise5_align", 32'(rise5_last % 30), 32'd15);
    check("fall5_align", 32'(fall5_last % 30), 32'd0);
    check("edges5", 32'(edges5), 32'd20);
    check("per3", 32'(rise3_last - rise3_prev), 32'd90);
    check("high3", 32'(high3), 32'd45);
    check("edges3", 32'(edges3), 32'd33);
    check("per7", 32'(rise7_last - rise7_prev), 32'd210);
    check("high7", 32'(high7), 32'd105);
    check("edges7", 32'(edges7), 32'd14);

    // The last rising edge raised out5. Apply reset 40 ns later; the output must fall without a clock edge.
    #39 check("pre_mid_rst_d5", 32'(out5), 32'd1);
    rst = 1'b0;
    #1;
    check("mid_rst_d5", 32'(out5), 32'd0);
    check("mid_rst_d7", 32'(out7), 32'd0);
    check("mid_rst_cnt5", 32'(u_d5.cnt), 32'd4);

    // While reset is held, clock edges have no effect.
    for (int e = 0; e < 3; e++) begin
      @(clk_in);
      #1;
      check("hold_d5", 32'(out5), 32'd0);
      check("hold_cnt5", 32'(u_d5.cnt), 32'd4);
    end

    // Release reset while the clock is high. The next falling edge is ignored, and the rising edge after it restarts the output.
    if (!clk_in) @(posedge clk_in);
    #3 rst = 1'b1;
    @(negedge clk_in);
    #1;
    check("ign_neg_d5", 32'(out5), 32'd0);
    check("ign_neg_cnt5", 32'(u_d5.cnt), 32'd4);
    @(posedge clk_in);
    #1;
    run_halves(30, "run2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/clock_div_five.md
CLOCK_DIV_FIVE -- requirements
Module: clock_div_five

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset; clock port clk_in, reset port rst.
REQ-002 Parameter: DIV, default 5, division ratio (odd integer, 3..31); all other values SHALL be rejected at elaboration.
REQ-003 Parameter: CNT_W, default 5, counter width; SHALL be at least clog2(DIV).
REQ-004 Port: clk_in  input  1  source clock, both edges used.
REQ-005 Port: rst  input  1  asynchronous active-low reset (0 = reset asserted).
REQ-006 Port: clk_div_5  output  1  divided clock: frequency clk_in/DIV, 50% duty cycle.

Function
REQ-007 Counter cnt (CNT_W bits) SHALL advance on every clk_in rising edge: cnt <= (cnt == DIV-1) ? 0 : cnt+1.
REQ-008 Rising-edge phase register pos_q SHALL load 1 when the new cnt value is < (DIV-1)/2, else 0; for DIV=5, high for new cnt ∈ {0,1}.
REQ-009 Falling-edge phase register neg_q SHALL sample pos_q on every clk_in falling edge.
REQ-010 clk_div_5 SHALL equal pos_q OR neg_q, with no further logic on the output path.
REQ-011 Period of clk_div_5 SHALL be exactly DIV clk_in periods.
REQ-012 High time SHALL be DIV/2 clk_in periods (2.5 for DIV=5); low time SHALL equal high time.
REQ-013 clk_div_5 rising edges SHALL align to clk_in rising edges (pos_q rise).
REQ-014 clk_div_5 falling edges SHALL align to clk_in falling edges (neg_q fall).
REQ-015 The output SHALL be glitch-free:
  - rise occurs only while neg_q = 0;
  - fall occurs only while pos_q = 0.
REQ-016 Counter wrap DIV-1 -> 0 SHALL occur without a skipped or repeated state.
REQ-017 Counter values >= DIV (unreachable in normal operation) SHALL recover to 0 on the next rising edge.
REQ-018 Output latency: the first clk_div_5 rising edge SHALL coincide with the first clk_in rising edge after reset release.

Reset
REQ-019 While rst = 0, asynchronously and regardless of clk_in:
  - cnt = DIV-1;
  - pos_q = 0;
  - neg_q = 0;
  - clk_div_5 = 0.
REQ-020 Reset asserted mid-period SHALL force clk_div_5 low immediately, with no wait for any clock edge.
REQ-021 While rst is held low, clk_in edges SHALL have no effect.
REQ-022 After rst rises, the first clk_in rising edge SHALL set cnt = 0 and pos_q = 1.
REQ-023 If rst rises while clk_in is high, the following falling edge SHALL be ignored only if no rising edge has occurred since release; neg_q then stays 0.

Verification
REQ-024 Reset: rst = 0 for 2 clk_in cycles -> clk_div_5 = 0 throughout; counter holds 4.
REQ-025 Steady state: clk_in period 30 ns, rst released -> first clk_div_5 rise at first clk_in posedge; clk_div_5 period 150 ns, high 75 ns, low 75 ns, for at least 10 output periods.
REQ-026 Edge alignment: clk_div_5 rises coincide with clk_in posedges; falls coincide with clk_in negedges, 2.5 cycles after each rise.
REQ-027 Mid-operation reset: rst pulled low 40 ns after a clk_div_5 rise -> clk_div_5 = 0 within the same timestep; after release, the first posedge restarts the 75 ns high phase.
REQ-028 Glitch check: sample clk_div_5 at every clk_in edge and every pos_q/neg_q change -> exactly one rise and one fall per 5 input cycles, no zero-width pulses.
REQ-029 Parameter sweep: DIV=3 -> period 3 cycles, high 1.5 cycles; DIV=7 -> period 7 cycles, high 3.5 cycles.
